// File: rtl/scan_counter_seg7.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// scan_counter_seg7
//
// Multi-digit up/down counter (hex or BCD digits) with a prescaled count tick,
// synchronous load and a terminal-count carry pulse. It drives a single
// time-multiplexed 7-segment bus with one active-low anode select per digit.
//
// Parameters
//   DIGITS    number of 4-bit digits, count width W = 4*DIGITS (1..8)
//   BCD       0 = hex digits 0..F, 1 = decimal digits 0..9
//   PRESCALE  enabled clocks per count tick (>=1)
//   SCAN_DIV  clocks each digit stays on the display (>=1)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   enable     in   1 = prescaler runs and count ticks, 0 = hold
//   upDown     in   1 = count up, 0 = count down (sampled on ticks)
//   load       in   synchronous load strobe (wins over a tick)
//   loadValue  in   W-bit value taken on load
//   count      out  W-bit current count, digit 0 in [3:0]
//   carry      out  one-cycle pulse after a wrapping tick
//   seg7       out  active-low segments {a,b,c,d,e,f,g}
//   an         out  active-low digit selects, one-hot-low
// -----------------------------------------------------------------------------
module scan_counter_seg7 #(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int PRESCALE = 1,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  upDown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadValue,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [6:0]            seg7,
    output logic [DIGITS-1:0]     an
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [3:0]        DIGIT_MAX  = (BCD != 0) ? 4'd9 : 4'd15;
    localparam logic [PW-1:0]     PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]     SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     INDEX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RESET   = ~(DIGITS'(1));
    localparam logic [6:0]        SEG_ZERO   = 7'b0000001;

    // Counter state
    logic [W-1:0]  count_reg;
    logic [PW-1:0] presc_reg;
    logic          carry_reg;

    // Scan / display state
    logic [SW-1:0]     scan_timer_reg;
    logic [IW-1:0]     scan_index_reg;
    logic [6:0]        seg7_reg;
    logic [DIGITS-1:0] an_reg;

    // Combinational helpers
    logic              tick;
    logic [W-1:0]      load_fixed;
    logic [W-1:0]      count_stepped;
    logic              wrap;
    logic [3:0]        digit_vals [DIGITS];
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] an_next;

    // Active-low 7-segment decode, bit 6 = segment a.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick = enable && (presc_reg == PRE_LAST);

    // Per-digit slices: load clamping (BCD digits above 9 saturate to 9),
    // digit extraction for the display mux and the anode pattern.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] ld_digit;
            assign ld_digit                = loadValue[4*gi +: 4];
            assign load_fixed[4*gi +: 4]   = ((BCD != 0) && (ld_digit > 4'd9)) ? 4'd9 : ld_digit;
            assign digit_vals[gi]          = count_reg[4*gi +: 4];
            assign an_next[gi]             = (scan_index_reg != IW'(gi));
        end
    endgenerate

    // Ripple carry/borrow through the digits. A digit only changes while the
    // ripple is still live; the ripple survives a digit that sits at its
    // wrap point (max going up, 0 going down). What leaves the top digit is
    // the terminal-count wrap.
    always_comb begin
        logic       ripple;
        logic       at_edge;
        logic [3:0] d;
        logic [3:0] nd;
        count_stepped = count_reg;
        ripple        = 1'b1;
        at_edge       = 1'b0;
        d             = 4'd0;
        nd            = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_reg[4*i +: 4];
            if (upDown) begin
                at_edge = (d == DIGIT_MAX);
                nd      = at_edge ? 4'd0 : d + 4'd1;
            end else begin
                at_edge = (d == 4'd0);
                nd      = at_edge ? DIGIT_MAX : d - 4'd1;
            end
            if (ripple) begin
                count_stepped[4*i +: 4] = nd;
            end
            ripple = ripple & at_edge;
        end
        wrap = ripple;
    end

    // Counter, prescaler and carry. Load beats tick; carry is only ever high
    // for the single cycle following a wrapping tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            presc_reg <= '0;
            carry_reg <= 1'b0;
        end else if (load) begin
            count_reg <= load_fixed;
            presc_reg <= '0;
            carry_reg <= 1'b0;
        end else if (tick) begin
            count_reg <= count_stepped;
            presc_reg <= '0;
            carry_reg <= wrap;
        end else if (enable) begin
            presc_reg <= presc_reg + 1'b1;
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= 1'b0;
        end
    end

    // Scan timer and digit index run on every clock, regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_timer_reg <= '0;
            scan_index_reg <= '0;
        end else if (scan_timer_reg == SCAN_LAST) begin
            scan_timer_reg <= '0;
            scan_index_reg <= (scan_index_reg == INDEX_LAST) ? '0 : scan_index_reg + 1'b1;
        end else begin
            scan_timer_reg <= scan_timer_reg + 1'b1;
        end
    end

    // Compare-based mux keeps the index width independent of the array size.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_index_reg == IW'(i)) begin
                cur_digit = digit_vals[i];
            end
        end
    end

    // Display outputs are registered from the current index and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg7_reg <= SEG_ZERO;
            an_reg   <= AN_RESET;
        end else begin
            seg7_reg <= seg_decode(cur_digit);
            an_reg   <= an_next;
        end
    end

    assign count = count_reg;
    assign carry = carry_reg;
    assign seg7  = seg7_reg;
    assign an    = an_reg;

endmodule

// File: tb/tb_scan_counter_seg7.sv
`timescale 1ns / 1ps
// Testbench for scan_counter_seg7. Three instances (DIGITS=2, SCAN_DIV=4)
// share one set of inputs: hex/PRESCALE=1, BCD/PRESCALE=1, hex/PRESCALE=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_scan_counter_seg7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;

    logic [7:0] hex_count, bcd_count, pre_count;
    logic       hex_carry, bcd_carry, pre_carry;
    logic [6:0] hex_seg7, bcd_seg7, pre_seg7;
    logic [1:0] hex_an, bcd_an, pre_an;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_A = 7'b0001000;

    always #1 clk = ~clk;

    scan_counter_seg7 #(.DIGITS(2), .BCD(0), .PRESCALE(1), .SCAN_DIV(4)) u_hex (
        .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
        .loadValue(load_value), .count(hex_count), .carry(hex_carry),
        .seg7(hex_seg7), .an(hex_an));

    scan_counter_seg7 #(.DIGITS(2), .BCD(1), .PRESCALE(1), .SCAN_DIV(4)) u_bcd (
        .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
        .loadValue(load_value), .count(bcd_count), .carry(bcd_carry),
        .seg7(bcd_seg7), .an(bcd_an));

    scan_counter_seg7 #(.DIGITS(2), .BCD(0), .PRESCALE(4), .SCAN_DIV(4)) u_pre (
        .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
        .loadValue(load_value), .count(pre_count), .carry(pre_carry),
        .seg7(pre_seg7), .an(pre_an));

    // Hold reset for two cycles and release it on a falling edge; the next
    // rising edge is the first one out of reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; up_down = 1'b0; load = 1'b0; load_value = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        $display("txn reset: hex cnt=%h carry=%b an=%b seg=%b", hex_count, hex_carry, hex_an, hex_seg7);
        checks++; if (hex_count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", hex_count); end
        checks++; if (hex_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", hex_carry); end
        checks++; if (hex_an !== 2'b10) begin failures++; $display("FAIL reset_an got=%b exp=10", hex_an); end
        checks++; if (hex_seg7 !== SEG_0) begin failures++; $display("FAIL reset_seg7 got=%b exp=%b", hex_seg7, SEG_0); end
        checks++; if (pre_count !== 8'h00) begin failures++; $display("FAIL reset_pre_count got=%h exp=00", pre_count); end
    endtask

    task automatic test_count_down();
        do_reset();
        enable = 1'b1; up_down = 1'b0;
        @(negedge clk);
        $display("txn down1: hex=%h c=%b bcd=%h c=%b", hex_count, hex_carry, bcd_count, bcd_carry);
        checks++; if (hex_count !== 8'hFF) begin failures++; $display("FAIL down_wrap_hex got=%h exp=ff", hex_count); end
        checks++; if (hex_carry !== 1'b1) begin failures++; $display("FAIL down_wrap_hex_carry got=%b exp=1", hex_carry); end
        checks++; if (bcd_count !== 8'h99) begin failures++; $display("FAIL down_wrap_bcd got=%h exp=99", bcd_count); end
        checks++; if (bcd_carry !== 1'b1) begin failures++; $display("FAIL down_wrap_bcd_carry got=%b exp=1", bcd_carry); end
        @(negedge clk);
        $display("txn down2: hex=%h c=%b bcd=%h", hex_count, hex_carry, bcd_count);
        checks++; if (hex_count !== 8'hFE) begin failures++; $display("FAIL down_fe got=%h exp=fe", hex_count); end
        checks++; if (hex_carry !== 1'b0) begin failures++; $display("FAIL down_carry_drop got=%b exp=0", hex_carry); end
        checks++; if (bcd_count !== 8'h98) begin failures++; $display("FAIL down_bcd_98 got=%h exp=98", bcd_count); end
        @(negedge clk);
        $display("txn down3: hex=%h", hex_count);
        checks++; if (hex_count !== 8'hFD) begin failures++; $display("FAIL down_fd got=%h exp=fd", hex_count); end
        repeat (14) @(negedge clk);
        $display("txn down17: hex=%h bcd=%h", hex_count, bcd_count);
        checks++; if (hex_count !== 8'hEF) begin failures++; $display("FAIL down_borrow_hex got=%h exp=ef", hex_count); end
        checks++; if (bcd_count !== 8'h83) begin failures++; $display("FAIL down_borrow_bcd got=%h exp=83", bcd_count); end
    endtask

    task automatic test_bcd_wrap();
        do_reset();
        enable = 1'b0; up_down = 1'b1; load = 1'b1; load_value = 8'h98;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        $display("txn bcd load98: bcd=%h c=%b", bcd_count, bcd_carry);
        checks++; if (bcd_count !== 8'h98) begin failures++; $display("FAIL bcd_load98 got=%h exp=98", bcd_count); end
        @(negedge clk);
        $display("txn bcd up: bcd=%h c=%b", bcd_count, bcd_carry);
        checks++; if (bcd_count !== 8'h99) begin failures++; $display("FAIL bcd_99 got=%h exp=99", bcd_count); end
        checks++; if (bcd_carry !== 1'b0) begin failures++; $display("FAIL bcd_99_carry got=%b exp=0", bcd_carry); end
        @(negedge clk);
        $display("txn bcd wrap: bcd=%h c=%b hex=%h", bcd_count, bcd_carry, hex_count);
        checks++; if (bcd_count !== 8'h00) begin failures++; $display("FAIL bcd_wrap got=%h exp=00", bcd_count); end
        checks++; if (bcd_carry !== 1'b1) begin failures++; $display("FAIL bcd_wrap_carry got=%b exp=1", bcd_carry); end
        checks++; if (hex_count !== 8'h9A) begin failures++; $display("FAIL hex_digit_a got=%h exp=9a", hex_count); end
        @(negedge clk);
        $display("txn bcd after: bcd=%h c=%b", bcd_count, bcd_carry);
        checks++; if (bcd_count !== 8'h01) begin failures++; $display("FAIL bcd_01 got=%h exp=01", bcd_count); end
        checks++; if (bcd_carry !== 1'b0) begin failures++; $display("FAIL bcd_01_carry got=%b exp=0", bcd_carry); end
        enable = 1'b0; load = 1'b1; load_value = 8'hAF;
        @(negedge clk);
        $display("txn load af: bcd=%h hex=%h", bcd_count, hex_count);
        checks++; if (bcd_count !== 8'h99) begin failures++; $display("FAIL bcd_clamp_af got=%h exp=99", bcd_count); end
        checks++; if (hex_count !== 8'hAF) begin failures++; $display("FAIL hex_load_af got=%h exp=af", hex_count); end
        load_value = 8'h3B;
        @(negedge clk);
        load = 1'b0;
        $display("txn load 3b: bcd=%h", bcd_count);
        checks++; if (bcd_count !== 8'h39) begin failures++; $display("FAIL bcd_clamp_3b got=%h exp=39", bcd_count); end
    endtask

    task automatic test_prescale();
        do_reset();
        enable = 1'b1; up_down = 1'b1;
        repeat (3) @(negedge clk);
        $display("txn pre 3clk: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h00) begin failures++; $display("FAIL pre_3clk got=%h exp=00", pre_count); end
        @(negedge clk);
        $display("txn pre 4clk: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h01) begin failures++; $display("FAIL pre_4clk got=%h exp=01", pre_count); end
        repeat (4) @(negedge clk);
        $display("txn pre 8clk: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h02) begin failures++; $display("FAIL pre_8clk got=%h exp=02", pre_count); end
        @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        $display("txn pre frozen: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h02) begin failures++; $display("FAIL pre_frozen got=%h exp=02", pre_count); end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn pre resume2: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h02) begin failures++; $display("FAIL pre_resume2 got=%h exp=02", pre_count); end
        @(negedge clk);
        $display("txn pre resume3: pre=%h", pre_count);
        checks++; if (pre_count !== 8'h03) begin failures++; $display("FAIL pre_resume3 got=%h exp=03", pre_count); end
    endtask

    task automatic test_load_tick();
        do_reset();
        enable = 1'b1; up_down = 1'b1;
        repeat (3) @(negedge clk);
        load = 1'b1; load_value = 8'h3C;
        @(negedge clk);
        load = 1'b0;
        $display("txn load+tick: pre=%h c=%b hex=%h", pre_count, pre_carry, hex_count);
        checks++; if (pre_count !== 8'h3C) begin failures++; $display("FAIL lt_pre_count got=%h exp=3c", pre_count); end
        checks++; if (pre_carry !== 1'b0) begin failures++; $display("FAIL lt_pre_carry got=%b exp=0", pre_carry); end
        checks++; if (hex_count !== 8'h3C) begin failures++; $display("FAIL lt_hex_count got=%h exp=3c", hex_count); end
        repeat (3) @(negedge clk);
        $display("txn lt 3clk: pre=%h hex=%h", pre_count, hex_count);
        checks++; if (pre_count !== 8'h3C) begin failures++; $display("FAIL lt_pre_hold got=%h exp=3c", pre_count); end
        checks++; if (hex_count !== 8'h3F) begin failures++; $display("FAIL lt_hex_3f got=%h exp=3f", hex_count); end
        @(negedge clk);
        $display("txn lt 4clk: pre=%h hex=%h", pre_count, hex_count);
        checks++; if (pre_count !== 8'h3D) begin failures++; $display("FAIL lt_pre_next got=%h exp=3d", pre_count); end
        checks++; if (hex_count !== 8'h40) begin failures++; $display("FAIL lt_hex_carry_digit got=%h exp=40", hex_count); end
        enable = 1'b0; load = 1'b1; load_value = 8'hFF;
        @(negedge clk);
        enable = 1'b1; load_value = 8'h00;
        @(negedge clk);
        load = 1'b0;
        $display("txn load over wrap: hex=%h c=%b", hex_count, hex_carry);
        checks++; if (hex_count !== 8'h00) begin failures++; $display("FAIL lw_count got=%h exp=00", hex_count); end
        checks++; if (hex_carry !== 1'b0) begin failures++; $display("FAIL lw_carry got=%b exp=0", hex_carry); end
        @(negedge clk);
        checks++; if (hex_count !== 8'h01) begin failures++; $display("FAIL lw_next got=%h exp=01", hex_count); end
    endtask

    task automatic test_direction();
        do_reset();
        enable = 1'b1; up_down = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (hex_count !== 8'h02) begin failures++; $display("FAIL dir_up got=%h exp=02", hex_count); end
        up_down = 1'b0;
        @(negedge clk);
        $display("txn dir flip: hex=%h", hex_count);
        checks++; if (hex_count !== 8'h01) begin failures++; $display("FAIL dir_down got=%h exp=01", hex_count); end
        up_down = 1'b1;
        @(negedge clk);
        checks++; if (hex_count !== 8'h02) begin failures++; $display("FAIL dir_up_again got=%h exp=02", hex_count); end
    endtask

    task automatic test_scan();
        do_reset();
        enable = 1'b0; load = 1'b1; load_value = 8'h5A;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        $display("txn scan e2: an=%b seg=%b", hex_an, hex_seg7);
        checks++; if (hex_an !== 2'b10) begin failures++; $display("FAIL scan_an_e2 got=%b exp=10", hex_an); end
        checks++; if (hex_seg7 !== SEG_A) begin failures++; $display("FAIL scan_seg_e2 got=%b exp=%b", hex_seg7, SEG_A); end
        repeat (2) @(negedge clk);
        checks++; if (hex_an !== 2'b10) begin failures++; $display("FAIL scan_an_e4 got=%b exp=10", hex_an); end
        @(negedge clk);
        $display("txn scan e5: an=%b seg=%b", hex_an, hex_seg7);
        checks++; if (hex_an !== 2'b01) begin failures++; $display("FAIL scan_an_e5 got=%b exp=01", hex_an); end
        checks++; if (hex_seg7 !== SEG_5) begin failures++; $display("FAIL scan_seg_e5 got=%b exp=%b", hex_seg7, SEG_5); end
        repeat (3) @(negedge clk);
        checks++; if (hex_an !== 2'b01) begin failures++; $display("FAIL scan_an_e8 got=%b exp=01", hex_an); end
        @(negedge clk);
        $display("txn scan e9: an=%b seg=%b cnt=%h", hex_an, hex_seg7, hex_count);
        checks++; if (hex_an !== 2'b10) begin failures++; $display("FAIL scan_an_e9 got=%b exp=10", hex_an); end
        checks++; if (hex_seg7 !== SEG_A) begin failures++; $display("FAIL scan_seg_e9 got=%b exp=%b", hex_seg7, SEG_A); end
        checks++; if (hex_count !== 8'h5A) begin failures++; $display("FAIL scan_count_hold got=%h exp=5a", hex_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1; up_down = 1'b1;
        repeat (6) @(negedge clk);
        $display("txn pre-rst: hex=%h an=%b", hex_count, hex_an);
        checks++; if (hex_an !== 2'b01) begin failures++; $display("FAIL ar_mid_an got=%b exp=01", hex_an); end
        checks++; if (hex_count !== 8'h06) begin failures++; $display("FAIL ar_mid_count got=%h exp=06", hex_count); end
        rst = 1'b1;
        #0.2;
        $display("txn async rst: hex=%h c=%b an=%b seg=%b", hex_count, hex_carry, hex_an, hex_seg7);
        checks++; if (hex_count !== 8'h00) begin failures++; $display("FAIL ar_count got=%h exp=00", hex_count); end
        checks++; if (hex_carry !== 1'b0) begin failures++; $display("FAIL ar_carry got=%b exp=0", hex_carry); end
        checks++; if (hex_an !== 2'b10) begin failures++; $display("FAIL ar_an got=%b exp=10", hex_an); end
        checks++; if (hex_seg7 !== SEG_0) begin failures++; $display("FAIL ar_seg7 got=%b exp=%b", hex_seg7, SEG_0); end
        repeat (2) @(negedge clk);
        checks++; if (hex_count !== 8'h00) begin failures++; $display("FAIL ar_hold got=%h exp=00", hex_count); end
        rst = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_down();
        test_bcd_wrap();
        test_prescale();
        test_load_tick();
        test_direction();
        test_scan();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
